// File: rtl/sync_core_matrix_pkg.sv
// Shared types and sizing helpers for the sync_core_matrix spin annealer.
// Optional noise feature is enabled by defining SYNC_CORE_MATRIX_NOISE_EN.
package core_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ENERGY,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int pair_count(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int addr_w(input int n);
        return (pair_count(n) > 1) ? $clog2(pair_count(n)) : 1;
    endfunction

    function automatic int energy_w(input int w, input int n);
        return w + $clog2(pair_count(n)) + 1;
    endfunction

    function automatic int pair_idx(input int i, input int j, input int n);
        return n * i - i * (i + 1) / 2 + j - i - 1;
    endfunction

endpackage

// File: rtl/sync_core_matrix_if.sv
// Weight-write handshake, run control and result bundle.
// Widths follow N and WEIGHT_W via core_matrix_pkg helpers.
interface sync_core_matrix_if #(
    parameter int N        = 8,
    parameter int WEIGHT_W = 3,
    parameter int CYC_W    = 16
);
    import core_matrix_pkg::*;

    localparam int AW = addr_w(N);
    localparam int EW = energy_w(WEIGHT_W, N);

    logic                       wt_valid;
    logic                       wt_ready;
    logic [AW-1:0]              wt_addr;
    logic [WEIGHT_W-1:0]        wt_data;
    logic                       start;
    logic [N-1:0]               spin_init;
    logic [CYC_W-1:0]           run_cycles;
    logic                       busy;
    logic                       done;
    logic [N-1:0]               spins;
    logic signed [EW-1:0]       energy;

    modport master (
        output wt_valid, wt_addr, wt_data, start, spin_init, run_cycles,
        input  wt_ready, busy, done, spins, energy
    );

    modport slave (
        input  wt_valid, wt_addr, wt_data, start, spin_init, run_cycles,
        output wt_ready, busy, done, spins, energy
    );

endinterface

// File: rtl/sync_core_matrix_weight_store.sv
// Upper-triangle coupling registers with symmetric row read and pair read.
// The diagonal entry of every row reads as zero.
module core_weight_store
    import core_matrix_pkg::*;
#(
    parameter int N        = 8,
    parameter int WEIGHT_W = 3,
    parameter int KW       = $clog2(N),
    parameter int AW       = addr_w(N)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_we,
    input  logic [AW-1:0]                 i_waddr,
    input  logic [WEIGHT_W-1:0]           i_wdata,
    input  logic [KW-1:0]                 i_k,
    output logic [N-1:0][WEIGHT_W-1:0]    o_row,
    input  logic [AW-1:0]                 i_paddr,
    output logic [WEIGHT_W-1:0]           o_pdata
);

    localparam int P = pair_count(N);

    logic [WEIGHT_W-1:0] r_w [P];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < P; p++) begin
                r_w[p] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < P)) begin
            r_w[i_waddr] <= i_wdata;
        end
    end

    // J_kj and J_jk share one register, indexed by the (min,max) pair.
    always_comb begin
        o_row = '0;
        for (int kk = 0; kk < N; kk++) begin
            if (KW'(kk) == i_k) begin
                for (int j = 0; j < N; j++) begin
                    if (j != kk) begin
                        o_row[j] = r_w[AW'(pair_idx(
                            (kk < j) ? kk : j,
                            (kk < j) ? j : kk, N))];
                    end
                end
            end
        end
    end

    assign o_pdata = r_w[i_paddr];

endmodule

// File: rtl/sync_core_matrix.sv
// Ising-style spin annealer: sequential local-field updates, then energy sum.
// Define SYNC_CORE_MATRIX_NOISE_EN for LFSR-driven random spin flips in RUN.
module sync_core_matrix #(
    parameter int N        = 8,
    parameter int WEIGHT_W = 3,
    parameter int CYC_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    sync_core_matrix_if.slave  bus
);
    import core_matrix_pkg::*;

    localparam int P  = pair_count(N);
    localparam int AW = addr_w(N);
    localparam int EW = energy_w(WEIGHT_W, N);
    localparam int KW = $clog2(N);
    localparam int HW = WEIGHT_W + $clog2(N) + 1;

    state_t                      r_state;
    state_t                      w_next;
    logic [N-1:0]                r_spins;
    logic [CYC_W-1:0]            r_cnt;
    logic [KW-1:0]               r_k;
    logic [AW-1:0]               r_pidx;
    logic [KW-1:0]               r_pi;
    logic [KW-1:0]               r_pj;
    logic signed [EW-1:0]        r_acc;

    logic                        w_we;
    logic [N-1:0][WEIGHT_W-1:0]  w_row;
    logic [WEIGHT_W-1:0]         w_pdata;
    logic signed [HW-1:0]        w_h;
    logic                        w_new;
    logic                        w_flip;
    logic signed [EW-1:0]        w_pw;
    logic                        w_same;

    assign bus.wt_ready = (r_state == ST_IDLE) && !bus.start;
    assign w_we         = bus.wt_valid && bus.wt_ready;

    core_weight_store #(
        .N        (N),
        .WEIGHT_W (WEIGHT_W),
        .KW       (KW),
        .AW       (AW)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (bus.wt_addr),
        .i_wdata (bus.wt_data),
        .i_k     (r_k),
        .o_row   (w_row),
        .i_paddr (r_pidx),
        .o_pdata (w_pdata)
    );

    // Diagonal reads zero, so spin k contributes nothing to its own field.
    always_comb begin
        w_h = '0;
        for (int j = 0; j < N; j++) begin
            if (r_spins[j]) begin
                w_h = w_h + {{(HW-WEIGHT_W){w_row[j][WEIGHT_W-1]}}, w_row[j]};
            end else begin
                w_h = w_h - {{(HW-WEIGHT_W){w_row[j][WEIGHT_W-1]}}, w_row[j]};
            end
        end
    end

    assign w_new = (w_h > 0) ? 1'b1 : ((w_h < 0) ? 1'b0 : r_spins[r_k]);

`ifdef SYNC_CORE_MATRIX_NOISE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == ST_RUN) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_flip = (r_lfsr[3:0] == 4'd0);
`else
    assign w_flip = 1'b0;
`endif

    // Equal spins give s_i*s_j=+1, so the term -J*s_i*s_j subtracts J.
    assign w_pw   = {{(EW-WEIGHT_W){w_pdata[WEIGHT_W-1]}}, w_pdata};
    assign w_same = (r_spins[r_pi] == r_spins[r_pj]);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.run_cycles == '0) ? ST_ENERGY : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CYC_W'(1)) begin
                    w_next = ST_ENERGY;
                end
            end
            ST_ENERGY: begin
                if (r_pidx == AW'(P - 1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_spins <= '1;
            r_cnt   <= '0;
            r_k     <= '0;
            r_pidx  <= '0;
            r_pi    <= '0;
            r_pj    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_spins <= bus.spin_init;
                        r_cnt   <= bus.run_cycles;
                        r_k     <= '0;
                        r_pidx  <= '0;
                        r_pi    <= '0;
                        r_pj    <= KW'(1);
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_spins[r_k] <= w_new ^ w_flip;
                    r_cnt        <= r_cnt - CYC_W'(1);
                    r_k          <= (r_k == KW'(N - 1)) ? '0 : r_k + KW'(1);
                end
                ST_ENERGY: begin
                    r_acc  <= w_same ? (r_acc - w_pw) : (r_acc + w_pw);
                    r_pidx <= r_pidx + AW'(1);
                    if (r_pj == KW'(N - 1)) begin
                        r_pi <= r_pi + KW'(1);
                        r_pj <= r_pi + KW'(2);
                    end else begin
                        r_pj <= r_pj + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.spins  = r_spins;
    assign bus.energy = r_acc;

endmodule

// File: tb/tb_sync_core_matrix.sv
// Scoreboard bench for sync_core_matrix (N=4, WEIGHT_W=3) against a
// plain-arithmetic Ising reference model.
module tb_sync_core_matrix;

    localparam int N  = 4;
    localparam int WW = 3;
    localparam int CW = 16;
    localparam int P  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_core_matrix_if #(.N(N), .WEIGHT_W(WW), .CYC_W(CW)) bus();

    sync_core_matrix #(.N(N), .WEIGHT_W(WW), .CYC_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] sp;
        int           en;
        int           cy;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   mj[N][N];
    int   pi_of[P];
    int   pj_of[P];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e_mon = q.pop_front();
                chk("spins", int'(bus.spins), int'(e_mon.sp));
                chk("energy", int'($signed(bus.energy)), e_mon.en);
                chk("done_cycle", cyc, e_mon.cy);
            end
        end
    end

    task automatic model_run(input logic [N-1:0] init, input int rc,
                             output logic [N-1:0] so, output int en);
        int s[N];
        int h;
        int k;
        for (int i = 0; i < N; i++) s[i] = init[i] ? 1 : -1;
        k = 0;
        repeat (rc) begin
            h = 0;
            for (int j = 0; j < N; j++) if (j != k) h += mj[k][j] * s[j];
            if (h > 0) s[k] = 1;
            else if (h < 0) s[k] = -1;
            k = (k + 1) % N;
        end
        en = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                en -= mj[i][j] * s[i] * s[j];
        for (int i = 0; i < N; i++) so[i] = (s[i] > 0);
    endtask

    task automatic wr(input int addr, input logic [WW-1:0] d);
        bus.wt_valid = 1'b1;
        bus.wt_addr  = 3'(addr);
        bus.wt_data  = d;
        chk("wt_ready_idle", int'(bus.wt_ready), 1);
        step();
        bus.wt_valid = 1'b0;
        if (addr < P) begin
            mj[pi_of[addr]][pj_of[addr]] = int'($signed(d));
            mj[pj_of[addr]][pi_of[addr]] = int'($signed(d));
        end
    endtask

    task automatic push(input logic [N-1:0] sp, input int en, input int rc);
        exp_t e;
        e.sp = sp;
        e.en = en;
        e.cy = cyc + 1 + rc + P;
        q.push_back(e);
    endtask

    task automatic issue(input logic [N-1:0] init, input int rc);
        bus.start      = 1'b1;
        bus.spin_init  = init;
        bus.run_cycles = 16'(rc);
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_model(input logic [N-1:0] init, input int rc);
        logic [N-1:0] so;
        int en;
        model_run(init, rc, so, en);
        push(so, en, rc);
        issue(init, rc);
    endtask

    task automatic run_const(input logic [N-1:0] init, input int rc,
                             input logic [N-1:0] sp, input int en);
        push(sp, en, rc);
        issue(init, rc);
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        step();
    endtask

    task automatic chk_reset_vals();
        chk("rst_spins", int'(bus.spins), 15);
        chk("rst_energy", int'($signed(bus.energy)), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wt_ready", int'(bus.wt_ready), 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mj[i][j] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        logic [N-1:0] so;
        int en;
        bus.wt_valid   = 1'b0;
        bus.wt_addr    = '0;
        bus.wt_data    = '0;
        bus.start      = 1'b0;
        bus.spin_init  = '0;
        bus.run_cycles = '0;
        clear_model();
        idx = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                pi_of[idx] = i;
                pj_of[idx] = j;
                idx++;
            end

        repeat (3) step();
        rst = 1'b0;
        chk_reset_vals();

        run_const(4'b1010, 8, 4'b1010, 0);
        wait_sb(100);

        for (int p = 0; p < P; p++) wr(p, 3'b001);
        run_const(4'b0001, 4, 4'b0000, -6);
        wait_sb(100);

        for (int p = 0; p < P; p++) wr(p, 3'b000);
        wr(0, 3'b101);
        run_const(4'b1111, 2, 4'b1110, -3);
        wait_sb(100);

        run_const(4'b0110, 0, 4'b0110, -3);
        wait_sb(100);

        for (int p = 0; p < P; p++) wr(p, 3'($urandom_range(0, 7)));
        run_model(4'b1001, 8);
        repeat (3) step();
        bus.wt_valid   = 1'b1;
        bus.wt_addr    = 3'd0;
        bus.wt_data    = 3'b011;
        bus.start      = 1'b1;
        bus.spin_init  = 4'b0101;
        bus.run_cycles = 16'd3;
        #1;
        chk("wt_ready_busy", int'(bus.wt_ready), 0);
        chk("busy_in_run", int'(bus.busy), 1);
        step();
        bus.wt_valid = 1'b0;
        bus.start    = 1'b0;
        wait_sb(100);
        repeat (20) step();
        run_model(4'b0110, 5);
        wait_sb(100);

        bus.wt_valid  = 1'b1;
        bus.wt_addr   = 3'd1;
        bus.wt_data   = 3'b010;
        bus.start     = 1'b1;
        #1;
        chk("wt_ready_vs_start", int'(bus.wt_ready), 0);
        bus.wt_valid  = 1'b0;
        bus.start     = 1'b0;
        run_model(4'b1100, 6);
        wait_sb(100);

        wr(6, 3'b111);
        wr(7, 3'b011);
        run_model(4'b0011, 7);
        wait_sb(100);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4))
                    wr($urandom_range(0, 7), 3'($urandom_range(0, 7)));
            end
            run_model(4'($urandom), $urandom_range(0, 20));
            wait_sb(100);
        end

        model_run(4'b1010, 40, so, en);
        issue(4'b1010, 40);
        repeat (10) step();
        chk("busy_before_abort", int'(bus.busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        chk_reset_vals();
        repeat (60) step();
        chk("idle_after_abort", int'(bus.busy), 0);

        run_model(4'b1010, 3);
        wait_sb(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_core_matrix.md
SYNC_CORE_MATRIX -- requirements
Module: sync_core_matrix

Interface
REQ-001 Parameter N, default 8: number of spins, 2..32.
REQ-002 Parameter WEIGHT_W, default 3: signed two's-complement coupling width.
REQ-003 Parameter CYC_W, default 16: run-length counter width.
REQ-004 clk  in  1  single clock; every flop is rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wt_valid  in  1  weight write request.
REQ-007 wt_ready  out  1  weight write accepted when high with wt_valid.
REQ-008 wt_addr  in  clog2(P)  pair index, where P = N*(N-1)/2. Order is (0,1)(0,2)..(0,N-1)(1,2)..(N-2,N-1). Index(i,j) = N*i - i*(i+1)/2 + j - i - 1.
REQ-009 wt_data  in  WEIGHT_W  signed J_ij.
REQ-010 start  in  1  one-cycle run request.
REQ-011 spin_init  in  N  initial spins, sampled on accepted start. Bit 1 = +1, bit 0 = -1.
REQ-012 run_cycles  in  CYC_W  number of single-spin updates, sampled on accepted start.
REQ-013 busy  out  1  high in every non-IDLE state.
REQ-014 done  out  1  one-cycle pulse when result is valid.
REQ-015 spins  out  N  current spin state.
REQ-016 energy  out  EW signed, where EW = WEIGHT_W + clog2(P) + 1.

Function
REQ-017 FSM states: IDLE, RUN, ENERGY, DONE.
- IDLE -> RUN on start.
- RUN -> ENERGY when the update count is exhausted.
- ENERGY -> DONE after P cycles.
- DONE -> IDLE after one cycle.
REQ-018 wt_ready = (state==IDLE) && !start. When start and wt_valid arrive together, start wins and the write is not taken.
REQ-019 An accepted write stores wt_data at wt_addr on that edge. Writes with wt_addr >= P are accepted and discarded.
REQ-020 start outside IDLE is ignored.
REQ-021 Accepted start in cycle T:
- spins <= spin_init.
- update counter <= run_cycles.
- spin index <= 0.
- energy accumulator <= 0.
REQ-022 RUN performs one update per cycle on spin k:
- h_k = sum over j != k of J_kj*s_j, with width WEIGHT_W + clog2(N) + 1.
- h_k > 0 sets s_k = +1; h_k < 0 sets s_k = -1; h_k = 0 keeps s_k.
- k increments and wraps N-1 -> 0.
- Counter decrements.
REQ-023 Exactly run_cycles updates occur. run_cycles = 0 skips RUN (IDLE -> ENERGY directly).
REQ-024 ENERGY visits one pair per cycle in index order and accumulates E = -sum J_ij*s_i*s_j. Spins are frozen during ENERGY.
REQ-025 done is high in cycle T + 1 + run_cycles + P. energy and spins are valid from then until the next accepted start.
REQ-026 Weight storage is symmetric: J_ji reads J_ij. The diagonal is implicitly 0.

Reset
REQ-027 On rst, at the next edge:
- state=IDLE, busy=0, done=0.
- spins = all 1.
- energy=0.
- all weights = 0.
- counters = 0.
REQ-028 rst mid-RUN or mid-ENERGY aborts with no done pulse. rst has priority over start and wt_valid.

Configuration
REQ-029 Macro SYNC_CORE_MATRIX_NOISE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) steps every RUN cycle. When lfsr[3:0] == 0, the computed update of s_k is inverted.
- Undefined: no LFSR logic is present and updates are deterministic per REQ-022.

Structure
REQ-030 Package core_matrix_pkg holds:
- the state enum;
- the pair-index function;
- the P and EW width functions;
- LFSR seed and taps.
REQ-031 Sub-module core_weight_store holds P x WEIGHT_W registers. It has one write port and combinational row reads J_k* for the local field, plus the pair read for ENERGY.

Verification (N=4, WEIGHT_W=3, P=6)
REQ-032 Reset -> spins=4'b1111, energy=0, busy=0, done=0, wt_ready=1.
REQ-033 All J=0, start with spin_init=4'b1010, run_cycles=8 -> done at T+15, spins=4'b1010, energy=0.
REQ-034 All J=+1, spin_init=4'b0001, run_cycles=4 -> spins=4'b0000, energy=-6.
REQ-035 J01=-3 and others 0, spin_init=4'b1111, run_cycles=2 -> spins=4'b1110, energy=-3.
REQ-036 Write attempted while busy, and start while busy -> wt_ready=0, weights unchanged, no second run.
REQ-037 run_cycles=0, spin_init=4'b0110 -> done at T+7, spins=4'b0110. Separately, rst asserted mid-RUN -> no done and REQ-032 values.
